// File: rtl/serial_addsub_if.sv
// Request/result bus of the bit-serial add/sub/compare sequencer.
// The sequencer side uses the slave modport; the requester/consumer side uses master.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  // Valid/ready rules on both channels: a transfer happens on a rising clock edge
  // where valid and ready are both 1. Once valid is raised, it stays high and its
  // payload stays stable until that transfer. Ready may depend on the other channel.
  logic             start_valid;
  logic             start_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             altb;
  logic             agtb;
  logic             aeqb;
  logic             busy;

  modport master (
    output start_valid, op, a, b, res_ready,
    input  start_ready, res_valid, result, carry_out, altb, agtb, aeqb, busy
  );

  modport slave (
    input  start_valid, op, a, b, res_ready,
    output start_ready, res_valid, result, carry_out, altb, agtb, aeqb, busy
  );
endinterface

// File: rtl/serial_addsub_seq.sv
// Bit-serial add/sub/compare sequencer: one full-adder cell stepped LSB-first for WIDTH cycles.
// Optional macro SERIAL_ADDSUB_B2B_EN lets a new request be accepted in the cycle a result is taken.
module serial_addsub_seq #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_addsub_if.slave      bus,
  output logic [1:0]          state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             is_add_q, is_add_d;
  logic             is_cmp_q, is_cmp_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             altb_q, altb_d;
  logic             agtb_q, agtb_d;
  logic             aeqb_q, aeqb_d;

  logic             start_ready;
  logic             accept;
  logic             fa_a, fa_b, fa_sum, fa_cout;
  logic [WIDTH-1:0] acc_next;
  logic             diff_zero;

  `ifdef SERIAL_ADDSUB_B2B_EN
  // Ready in DONE follows res_ready combinationally so a new op can chain without a bubble.
  assign start_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & bus.res_ready);
  `else
  assign start_ready = (state_q == S_IDLE);
  `endif

  assign accept = bus.start_valid & start_ready;

  assign fa_a     = a_sr_q[0];
  assign fa_b     = b_sr_q[0];
  assign fa_sum   = fa_a ^ fa_b ^ carry_q;
  assign fa_cout  = (fa_a & fa_b) | (carry_q & (fa_a ^ fa_b));
  assign acc_next = {fa_sum, acc_q[WIDTH-1:1]};
  assign diff_zero = ~|acc_next;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    is_add_d    = is_add_q;
    is_cmp_d    = is_cmp_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    altb_d      = altb_q;
    agtb_d      = agtb_q;
    aeqb_d      = aeqb_q;

    case (state_q)
      S_SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = fa_cout;
        acc_d   = acc_next;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          cnt_d       = '0;
          result_d    = acc_next;
          // Subtraction runs as a + ~b + 1, so a missing final carry means a borrow.
          carry_out_d = is_add_q ? fa_cout : ~fa_cout;
          altb_d      = is_cmp_q & ~fa_cout;
          aeqb_d      = is_cmp_q & diff_zero;
          agtb_d      = is_cmp_q & fa_cout & ~diff_zero;
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accept can only happen in IDLE, or in DONE while the result is being taken.
    if (accept) begin
      state_d  = S_SHIFT;
      cnt_d    = '0;
      a_sr_d   = bus.a;
      b_sr_d   = (bus.op == 2'b00) ? bus.b : ~bus.b;
      acc_d    = '0;
      carry_d  = (bus.op != 2'b00);
      is_add_d = (bus.op == 2'b00);
      is_cmp_d = bus.op[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      is_add_q    <= 1'b0;
      is_cmp_q    <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      altb_q      <= 1'b0;
      agtb_q      <= 1'b0;
      aeqb_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      is_add_q    <= is_add_d;
      is_cmp_q    <= is_cmp_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      altb_q      <= altb_d;
      agtb_q      <= agtb_d;
      aeqb_q      <= aeqb_d;
    end
  end

  assign bus.start_ready = start_ready;
  assign bus.res_valid   = (state_q == S_DONE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.result      = result_q;
  assign bus.carry_out   = carry_out_q;
  assign bus.altb        = altb_q;
  assign bus.agtb        = agtb_q;
  assign bus.aeqb        = aeqb_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Randomized bench for serial_addsub_seq with an arithmetic reference model and scoreboard.
module tb_serial_addsub_seq;

  localparam int W = 8;
  `ifdef SERIAL_ADDSUB_B2B_EN
  localparam int PERIOD = W + 1;
  `else
  localparam int PERIOD = W + 2;
  `endif

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         n_checks;
  int         n_fail;
  int         cyc;
  logic [W+3:0] exp_q[$];

  serial_addsub_if #(.WIDTH(W)) bus ();

  serial_addsub_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain unsigned arithmetic. Packed as {altb, agtb, aeqb, carry, result}.
  function automatic logic [W+3:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, lt, gt, eq;
    lt = 1'b0; gt = 1'b0; eq = 1'b0;
    if (op == 2'b00) begin
      s = {1'b0, a} + {1'b0, b};
      r = s[W-1:0];
      c = s[W];
    end else begin
      r = a - b;
      c = (a < b);
      if (op[1]) begin
        lt = (a < b);
        gt = (a > b);
        eq = (a == b);
      end
    end
    return {lt, gt, eq, c, r};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W+3:0] e;
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", bus.result, e[W-1:0]);
          check("sb_carry", bus.carry_out, e[W]);
          check("sb_flags", {bus.altb, bus.agtb, bus.aeqb}, e[W+3:W+1]);
        end
      end
      if (bus.start_valid && bus.start_ready)
        exp_q.push_back(model(bus.op, bus.a, bus.b));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    int t;
    int lat;
    logic [W+3:0] e;
    e = model(op, a, b);
    @(posedge clk); #1;
    bus.start_valid = 1'b1;
    bus.op = op; bus.a = a; bus.b = b;
    bus.res_ready = 1'b0;
    t = 0;
    @(negedge clk);
    while (!bus.start_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.start_ready) begin
      check("accept_timeout", 0, 1);
      bus.start_valid = 1'b0;
      return;
    end
    // Accept edge; scramble the inputs to show they are ignored mid-operation.
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.op = 2'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin
        check("shift_start_ready", bus.start_ready, 0);
        check("shift_busy", bus.busy, 1);
      end
    end while (!bus.res_valid && lat < 100);
    check("latency", lat, W + 1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_valid", bus.res_valid, 1);
      check("hold_result", bus.result, e[W-1:0]);
      check("hold_flags", {bus.altb, bus.agtb, bus.aeqb, bus.carry_out}, e[W+3:W]);
      check("hold_start_ready", bus.start_ready, 0);
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    check("after_take_valid", bus.res_valid, 0);
    check("after_take_result", bus.result, e[W-1:0]);
    check("after_take_busy", bus.busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, bus.result, 0);
    check({tag, "_carry_flags"}, {bus.carry_out, bus.altb, bus.agtb, bus.aeqb}, 0);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_start_ready"}, bus.start_ready, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t, n, last;
    n_checks = 0; n_fail = 0;
    bus.start_valid = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.res_ready = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    // Directed vectors
    run_op(2'b00, 8'hFF, 8'h01, 0);
    run_op(2'b01, 8'h05, 8'h07, 0);
    run_op(2'b01, 8'h07, 8'h05, 0);
    run_op(2'b10, 8'h3C, 8'h3C, 1);
    run_op(2'b10, 8'h10, 8'h20, 0);
    run_op(2'b11, 8'h20, 8'h10, 0);
    run_op(2'b00, 8'hA5, 8'h5A, 5);

    // Random operations with random consumer stalls
    for (int i = 0; i < 30; i++)
      run_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), $urandom_range(0, 3));

    // Reset during the 4th SHIFT cycle
    @(posedge clk); #1;
    bus.start_valid = 1'b1; bus.op = 2'b00; bus.a = W'($urandom); bus.b = W'($urandom);
    t = 0;
    @(negedge clk);
    while (!bus.start_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rst_test_accept", bus.start_ready, 1);
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_reset_outputs("mid_shift_reset");
    @(posedge clk); #1 rst = 1'b1;
    run_op(2'b00, 8'h12, 8'h34, 0);

    // Throughput with start_valid held high and the consumer always ready
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    bus.start_valid = 1'b1;
    bus.op = 2'($urandom); bus.a = W'($urandom); bus.b = W'($urandom);
    last = -1; n = 0; t = 0;
    while (n < 6 && t < 300) begin
      @(negedge clk);
      t++;
      if (bus.start_valid && bus.start_ready) begin
        if (last >= 0) check("accept_period", cyc - last, PERIOD);
        last = cyc;
        n++;
        @(posedge clk); #1;
        bus.op = 2'($urandom); bus.a = W'($urandom); bus.b = W'($urandom);
      end
    end
    check("throughput_accepts", n, 6);
    bus.start_valid = 1'b0;
    t = 0;
    while ((exp_q.size() != 0 || bus.busy) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_busy", bus.busy, 0);
    check("sb_empty", exp_q.size(), 0);
    bus.res_ready = 1'b0;

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
